// File: rtl/alu_issue.sv
// alu_issue: execute-issue stage feeding the tiny16 ALU.
// Ports: instr valid/ready in, ALU drive/return, done/flags_q/illegal, debug read.
module alu_issue #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 8,
  parameter int ALU_LAT  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [15:0]      instr,
  output logic [3:0]       alu_opcode,
  output logic             alu_ar_flag,
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  output logic             alu_out_en,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [3:0]       alu_flags,
  output logic             done,
  output logic [3:0]       flags_q,
  output logic             illegal,
  input  logic [2:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WB
  } state_t;

  typedef enum logic [1:0] {
    K_NOP,
    K_LDI,
    K_ALU
  } kind_t;

  state_t           r_state;
  state_t           w_nxt;
  kind_t            r_kind;
  kind_t            w_kind;
  logic [2:0]       r_rd;
  logic [7:0]       r_imm;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_opc;
  logic             r_ar;
  logic [WIDTH-1:0] r_src1;
  logic [WIDTH-1:0] r_src2;
  logic [3:0]       r_flags;
  logic             r_ill;
  logic [WIDTH-1:0] r_regs [NUM_REGS];

  logic [3:0] w_op;
  logic       w_xfer;
  logic       w_is_ldi;
  logic       w_is_alu;
  logic       w_is_ill;
  logic       w_cnt_last;

  assign w_op     = instr[15:12];
  assign w_xfer   = instr_valid && (r_state == S_IDLE);
  assign w_is_ldi = (w_op == 4'b0001);
  assign w_is_alu = (w_op >= 4'b0011) && (w_op <= 4'b1011);
  assign w_is_ill = (w_op == 4'b0010) || (w_op >= 4'b1100);
  assign w_cnt_last = (r_cnt == CW'(ALU_LAT - 1));

  // Illegal ops retire like a NOP: no register write.
  always_comb begin
    w_kind = K_NOP;
    unique case (1'b1)
      w_is_ldi: w_kind = K_LDI;
      w_is_alu: w_kind = K_ALU;
      default:  w_kind = K_NOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_xfer) w_nxt = w_is_alu ? S_ISSUE : S_WB;
      end
      S_ISSUE: begin
        if (w_cnt_last) w_nxt = S_WB;
      end
      S_WB:    w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_kind  <= K_NOP;
      r_rd    <= '0;
      r_imm   <= '0;
      r_cnt   <= '0;
      r_opc   <= '0;
      r_ar    <= 1'b0;
      r_src1  <= '0;
      r_src2  <= '0;
      r_flags <= '0;
      r_ill   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      if (w_xfer) begin
        r_kind <= w_kind;
        r_rd   <= instr[10:8];
        r_imm  <= instr[7:0];
        if (w_is_alu) begin
          r_opc  <= w_op;
          r_ar   <= instr[11];
          r_src1 <= r_regs[instr[7:5]];
          r_src2 <= r_regs[instr[4:2]];
        end
        if (w_is_ill) r_ill <= 1'b1;
      end
      if (r_state == S_ISSUE) r_cnt <= r_cnt + CW'(1);
      else                    r_cnt <= '0;
      if (r_state == S_WB) begin
        unique case (r_kind)
          K_ALU: begin
            r_regs[r_rd] <= alu_out;
            r_flags      <= alu_flags;
          end
          K_LDI: r_regs[r_rd] <= {{(WIDTH-8){1'b0}}, r_imm};
          default: ;
        endcase
      end
    end
  end

  assign instr_ready = (r_state == S_IDLE);
  assign alu_out_en  = (r_state == S_ISSUE);
  assign done        = (r_state == S_WB);
  assign alu_opcode  = r_opc;
  assign alu_ar_flag = r_ar;
  assign alu_src1    = r_src1;
  assign alu_src2    = r_src2;
  assign flags_q     = r_flags;
  assign illegal     = r_ill;
  assign dbg_data    = r_regs[dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed bench for alu_issue with a behavioural ALU.
// ALU flags model: {zero, neg, opcode[1:0]}.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic [3:0]  alu_opcode;
  logic        alu_ar_flag;
  logic [15:0] alu_src1;
  logic [15:0] alu_src2;
  logic        alu_out_en;
  logic [15:0] alu_out = '0;
  logic [3:0]  alu_flags = '0;
  logic        done;
  logic [3:0]  flags_q;
  logic        illegal;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_oen  = 0;
  int n_xfer = 0;

  alu_issue dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_opcode  (alu_opcode),
    .alu_ar_flag (alu_ar_flag),
    .alu_src1    (alu_src1),
    .alu_src2    (alu_src2),
    .alu_out_en  (alu_out_en),
    .alu_out     (alu_out),
    .alu_flags   (alu_flags),
    .done        (done),
    .flags_q     (flags_q),
    .illegal     (illegal),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(
    input logic [3:0] op, input logic ar,
    input logic [15:0] a, input logic [15:0] b);
    logic [3:0] sh;
    sh = b[3:0];
    case (op)
      4'b0011: return a + b;
      4'b0100: return a - b;
      4'b0101: return a * b;
      4'b0110: return (b == 0) ? 16'hffff : a / b;
      4'b0111: return a & b;
      4'b1000: return a | b;
      4'b1001: return a ^ b;
      4'b1010: return ar ? ((a << sh) | (a >> (16 - sh))) : (a << sh);
      4'b1011: return ar ? ((a >> sh) | (a << (16 - sh))) : (a >> sh);
      default: return 16'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (alu_out_en) begin
      alu_out   <= alu_f(alu_opcode, alu_ar_flag, alu_src1, alu_src2);
      alu_flags <= {alu_f(alu_opcode, alu_ar_flag, alu_src1, alu_src2) == 16'h0,
                    alu_f(alu_opcode, alu_ar_flag, alu_src1, alu_src2) >> 15 == 16'h1,
                    alu_opcode[1:0]};
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (done) n_done++;
      if (alu_out_en) n_oen++;
      if (instr_valid && instr_ready) n_xfer++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op, input logic ar,
    input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, ar, rd, rs1, rs2, 2'b00};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] rd,
                                      input logic [7:0] imm);
    return {4'b0001, 1'b0, rd, imm};
  endfunction

  task automatic chk_reg(input string tag, input logic [2:0] a,
                         input logic [15:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic local_op(input string tag, input logic [15:0] ins);
    wait_ready();
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_oen"}, alu_out_en, 0);
    chk({tag, "_rdy_lo"}, instr_ready, 0);
    @(posedge clk);
    #1;
    chk({tag, "_done_lo"}, done, 0);
    chk({tag, "_rdy"}, instr_ready, 1);
  endtask

  task automatic alu_op(input string tag, input logic [15:0] ins,
    input logic [15:0] s1, input logic [15:0] s2,
    input logic [15:0] res, input logic [3:0] fl);
    wait_ready();
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    chk({tag, "_oen"}, alu_out_en, 1);
    chk({tag, "_src1"}, alu_src1, s1);
    chk({tag, "_src2"}, alu_src2, s2);
    chk({tag, "_opc"}, alu_opcode, ins[15:12]);
    chk({tag, "_ar"}, alu_ar_flag, ins[11]);
    chk({tag, "_rdy_lo1"}, instr_ready, 0);
    chk({tag, "_done_lo"}, done, 0);
    @(posedge clk);
    #1;
    chk({tag, "_oen_lo"}, alu_out_en, 0);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_rdy_lo2"}, instr_ready, 0);
    @(posedge clk);
    #1;
    chk({tag, "_done_end"}, done, 0);
    chk({tag, "_rdy"}, instr_ready, 1);
    chk({tag, "_flags"}, flags_q, fl);
    chk_reg({tag, "_rd"}, ins[10:8], res);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int x0;
    logic [15:0] b2b [3];

    #12;
    chk("rst_done", done, 0);
    chk("rst_oen", alu_out_en, 0);
    chk("rst_opc", alu_opcode, 0);
    chk("rst_ar", alu_ar_flag, 0);
    chk("rst_src1", alu_src1, 0);
    chk("rst_src2", alu_src2, 0);
    chk("rst_flags", flags_q, 0);
    chk("rst_ill", illegal, 0);
    chk("rst_rdy", instr_ready, 1);
    for (int i = 0; i < 8; i++) chk_reg("rst_reg", 3'(i), 16'h0);
    @(negedge clk);
    rst = 1'b1;

    local_op("ldi1", ldi(3'd1, 8'd10));
    chk_reg("ldi1_r1", 3'd1, 16'd10);
    local_op("ldi2", ldi(3'd2, 8'd5));
    chk_reg("ldi2_r2", 3'd2, 16'd5);
    chk("ldi_no_oen", n_oen, 0);
    chk("ldi_done_cnt", n_done, 2);

    alu_op("add", mk(4'b0011, 1'b0, 3'd3, 3'd1, 3'd2),
           16'd10, 16'd5, 16'd15, 4'b0011);
    chk("add_oen_cnt", n_oen, 1);
    alu_op("sub", mk(4'b0100, 1'b0, 3'd4, 3'd1, 3'd2),
           16'd10, 16'd5, 16'd5, 4'b0000);
    alu_op("mul", mk(4'b0101, 1'b0, 3'd4, 3'd1, 3'd2),
           16'd10, 16'd5, 16'd50, 4'b0001);
    alu_op("rol", mk(4'b1010, 1'b1, 3'd5, 3'd1, 3'd2),
           16'd10, 16'd5, 16'd320, 4'b0010);

    local_op("ill", mk(4'b1100, 1'b0, 3'd1, 3'd2, 3'd3));
    chk("ill_flag", illegal, 1);
    chk("ill_flags", flags_q, 4'b0010);
    chk_reg("ill_r1", 3'd1, 16'd10);
    chk_reg("ill_r3", 3'd3, 16'd15);
    chk_reg("ill_r4", 3'd4, 16'd50);
    chk_reg("ill_r5", 3'd5, 16'd320);
    local_op("nop", mk(4'b0000, 1'b0, 3'd2, 3'd1, 3'd1));
    chk("nop_ill", illegal, 1);
    chk_reg("nop_r2", 3'd2, 16'd5);

    // r6 = r6 + r2 three times: a drop or duplicate changes the sum
    b2b[0] = mk(4'b0011, 1'b0, 3'd6, 3'd6, 3'd2);
    b2b[1] = b2b[0];
    b2b[2] = b2b[0];
    d0 = n_done;
    x0 = n_xfer;
    instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr = b2b[i];
      wait_ready();
      @(posedge clk);
      #1;
    end
    instr_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_done", n_done - d0, 3);
    chk("b2b_xfer", n_xfer - x0, 3);
    chk_reg("b2b_r6", 3'd6, 16'd15);
    chk("b2b_flags", flags_q, 4'b0011);

    wait_ready();
    instr = mk(4'b0011, 1'b0, 3'd7, 3'd1, 3'd2);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    chk("mid_oen", alu_out_en, 1);
    d0 = n_done;
    rst = 1'b0;
    #1;
    chk("mid_rst_oen", alu_out_en, 0);
    chk("mid_rst_rdy", instr_ready, 1);
    chk("mid_rst_flags", flags_q, 0);
    chk("mid_rst_ill", illegal, 0);
    chk("mid_rst_src1", alu_src1, 0);
    for (int i = 0; i < 8; i++) chk_reg("mid_rst_reg", 3'(i), 16'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_done", n_done - d0, 0);
    chk_reg("post_rst_r7", 3'd7, 16'h0);
    chk("post_rst_oen", alu_out_en, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
